// File: rtl/sub16_serial.sv
// Serial 16-bit subtractor: A - B - Bin, processed STEP_W bits per cycle, LSB slice first.
// Results (Diff, Bout, Zero, Ovf) are registered and held until the next completion.
module sub16_serial #(
    parameter int unsigned STEP_W = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Start,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        Bin,
    output logic        Busy,
    output logic        Done,
    output logic [15:0] Diff,
    output logic        Bout,
    output logic        Zero,
    output logic        Ovf
);

    localparam int unsigned N        = 16 / STEP_W;
    localparam int unsigned CntW     = (N > 1) ? $clog2(N) : 1;
    localparam logic [CntW-1:0] LastStep = CntW'(N - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [15:0]     a_sh_q, a_sh_d;
    logic [15:0]     b_sh_q, b_sh_d;
    logic [15:0]     acc_q, acc_d;
    logic            a_msb_q, a_msb_d;
    logic            b_msb_q, b_msb_d;
    logic            borrow_q, borrow_d;
    logic [CntW-1:0] step_q, step_d;
    logic [15:0]     diff_q, diff_d;
    logic            bout_q, bout_d;
    logic            zero_q, zero_d;
    logic            ovf_q, ovf_d;

    logic [STEP_W:0] slice_res;
    logic [15:0]     slice_ext;
    logic [15:0]     acc_next;

    // One slice of borrow-propagating subtraction; the top bit of slice_res is the borrow out.
    always_comb begin
        slice_res = {1'b0, a_sh_q[STEP_W-1:0]} - {1'b0, b_sh_q[STEP_W-1:0]}
                    - {{STEP_W{1'b0}}, borrow_q};
        slice_ext = 16'(slice_res[STEP_W-1:0]) << (16 - STEP_W);
        acc_next  = (acc_q >> STEP_W) | slice_ext;
    end

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        acc_d    = acc_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        borrow_d = borrow_q;
        step_d   = step_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;

        case (state_q)
            StIdle, StDone: begin
                if (Start) begin
                    a_sh_d   = A;
                    b_sh_d   = B;
                    a_msb_d  = A[15];
                    b_msb_d  = B[15];
                    borrow_d = Bin;
                    acc_d    = 16'h0000;
                    step_d   = '0;
                    state_d  = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                a_sh_d   = a_sh_q >> STEP_W;
                b_sh_d   = b_sh_q >> STEP_W;
                borrow_d = slice_res[STEP_W];
                acc_d    = acc_next;
                step_d   = step_q + CntW'(1);
                if (step_q == LastStep) begin
                    state_d = StDone;
                    step_d  = '0;
                    diff_d  = acc_next;
                    bout_d  = slice_res[STEP_W];
                    zero_d  = (acc_next == 16'h0000);
                    // Operands of differing sign overflow when the result sign departs from A.
                    ovf_d   = (a_msb_q != b_msb_q) && (acc_next[15] != a_msb_q);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= StIdle;
            a_sh_q   <= 16'h0000;
            b_sh_q   <= 16'h0000;
            acc_q    <= 16'h0000;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            borrow_q <= 1'b0;
            step_q   <= '0;
            diff_q   <= 16'h0000;
            bout_q   <= 1'b0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            acc_q    <= acc_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            borrow_q <= borrow_d;
            step_q   <= step_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end

    assign Busy = (state_q == StRun);
    assign Done = (state_q == StDone);
    assign Diff = diff_q;
    assign Bout = bout_q;
    assign Zero = zero_q;
    assign Ovf  = ovf_q;

endmodule

// File: tb/tb_sub16_serial.sv
// Scoreboard bench for sub16_serial at STEP_W = 1, 4 and 16 against an arithmetic reference.
module tb_sub16_serial;

    typedef struct {
        logic [15:0] diff;
        logic        bout;
        logic        zero;
        logic        ovf;
        int          when;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start  [3];
    logic [15:0] a_in   [3];
    logic [15:0] b_in   [3];
    logic        bin_in [3];
    logic        busy   [3];
    logic        done   [3];
    logic [15:0] diff   [3];
    logic        bout   [3];
    logic        zero   [3];
    logic        ovf    [3];

    exp_t exp_q[3][$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    sub16_serial #(.STEP_W(1)) dut_w1 (
        .CLK(CLK), .RST(RST), .Start(start[0]), .A(a_in[0]), .B(b_in[0]), .Bin(bin_in[0]),
        .Busy(busy[0]), .Done(done[0]), .Diff(diff[0]), .Bout(bout[0]), .Zero(zero[0]),
        .Ovf(ovf[0])
    );
    sub16_serial #(.STEP_W(4)) dut_w4 (
        .CLK(CLK), .RST(RST), .Start(start[1]), .A(a_in[1]), .B(b_in[1]), .Bin(bin_in[1]),
        .Busy(busy[1]), .Done(done[1]), .Diff(diff[1]), .Bout(bout[1]), .Zero(zero[1]),
        .Ovf(ovf[1])
    );
    sub16_serial #(.STEP_W(16)) dut_w16 (
        .CLK(CLK), .RST(RST), .Start(start[2]), .A(a_in[2]), .B(b_in[2]), .Bin(bin_in[2]),
        .Busy(busy[2]), .Done(done[2]), .Diff(diff[2]), .Bout(bout[2]), .Zero(zero[2]),
        .Ovf(ovf[2])
    );

    function automatic int lat(int k);
        return (k == 0) ? 16 : (k == 1) ? 4 : 1;
    endfunction

    // Reference: plain integer arithmetic on the operands.
    function automatic exp_t model(logic [15:0] a, logic [15:0] b, logic bi, int when);
        exp_t e;
        int   ud;
        int   sd;
        ud     = int'(a) - int'(b) - int'(bi);
        sd     = int'($signed(a)) - int'($signed(b)) - int'(bi);
        e.diff = ud[15:0];
        e.bout = (ud < 0);
        e.zero = (e.diff == 16'h0000);
        e.ovf  = (sd < -32768) || (sd > 32767);
        e.when = when;
        return e;
    endfunction

    task automatic check(string name, int k, int act, int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h, expected %0h (cycle %0d)", name, k, act, expv, cyc);
        end
    endtask

    // Monitor: every Done must match the oldest outstanding expectation, on the right cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            for (int k = 0; k < 3; k++) begin
                if (done[k] === 1'b1) begin
                    if (exp_q[k].size() == 0) begin
                        check("unexpected_done", k, 1, 0);
                    end else begin
                        e = exp_q[k].pop_front();
                        check("diff", k, int'(diff[k]), int'(e.diff));
                        check("bout", k, int'(bout[k]), int'(e.bout));
                        check("zero", k, int'(zero[k]), int'(e.zero));
                        check("ovf", k, int'(ovf[k]), int'(e.ovf));
                        check("done_cycle", k, cyc, e.when);
                    end
                end
            end
        end
    end

    task automatic issue(int k, logic [15:0] a, logic [15:0] b, logic bi);
        start[k]  = 1'b1;
        a_in[k]   = a;
        b_in[k]   = b;
        bin_in[k] = bi;
        @(posedge CLK);
        #1;
        exp_q[k].push_back(model(a, b, bi, cyc + lat(k)));
        start[k] = 1'b0;
        check("busy_after_start", k, int'(busy[k]), 1);
        // Scramble inputs while running; the result must not depend on them.
        a_in[k]   = 16'($urandom);
        b_in[k]   = 16'($urandom);
        bin_in[k] = 1'($urandom);
    endtask

    // Start held high from issue through the DONE cycle: second op accepted immediately.
    task automatic issue_hold(int k, logic [15:0] a1, logic [15:0] b1, logic bi1,
                              logic [15:0] a2, logic [15:0] b2, logic bi2);
        start[k]  = 1'b1;
        a_in[k]   = a1;
        b_in[k]   = b1;
        bin_in[k] = bi1;
        @(posedge CLK);
        #1;
        exp_q[k].push_back(model(a1, b1, bi1, cyc + lat(k)));
        a_in[k]   = a2;
        b_in[k]   = b2;
        bin_in[k] = bi2;
        repeat (lat(k) + 1) @(posedge CLK);
        #1;
        exp_q[k].push_back(model(a2, b2, bi2, cyc + lat(k)));
        start[k] = 1'b0;
    endtask

    task automatic drain(int k);
        for (int i = 0; i < 80 && exp_q[k].size() > 0; i++) begin
            @(posedge CLK);
            #2;
        end
        if (exp_q[k].size() > 0) begin
            check("done_timeout", k, exp_q[k].size(), 0);
            exp_q[k].delete();
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic check_reset_state(int k);
        check("rst_busy", k, int'(busy[k]), 0);
        check("rst_done", k, int'(done[k]), 0);
        check("rst_diff", k, int'(diff[k]), 0);
        check("rst_zero", k, int'(zero[k]), 1);
        check("rst_bout", k, int'(bout[k]), 0);
        check("rst_ovf", k, int'(ovf[k]), 0);
    endtask

    initial begin
        logic [15:0] ra, rb, rc, rd;
        for (int k = 0; k < 3; k++) begin
            start[k]  = 1'b0;
            a_in[k]   = 16'h0000;
            b_in[k]   = 16'h0000;
            bin_in[k] = 1'b0;
        end
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        for (int k = 0; k < 3; k++) check_reset_state(k);

        for (int k = 0; k < 3; k++) begin
            issue(k, 16'h0205, 16'h0003, 1'b0); drain(k);
            issue(k, 16'h0000, 16'h00FF, 1'b0); drain(k);
            issue(k, 16'hFFFF, 16'hFFFF, 1'b1); drain(k);
            issue(k, 16'h8000, 16'h0001, 1'b0); drain(k);
            issue(k, 16'h1234, 16'h1234, 1'b0); drain(k);
            issue(k, 16'h7FFF, 16'hFFFF, 1'b1); drain(k);
            issue_hold(k, 16'h0100, 16'h0001, 1'b1, 16'h0001, 16'h0100, 1'b0);
            drain(k);
        end

        // Start re-pulsed mid-RUN with different operands must be ignored.
        for (int k = 0; k < 2; k++) begin
            issue(k, 16'hA5A5, 16'h1111, 1'b1);
            start[k] = 1'b1;
            a_in[k]  = 16'h0001;
            b_in[k]  = 16'h0002;
            @(posedge CLK);
            #1;
            start[k] = 1'b0;
            drain(k);
        end

        // Reset at RUN step 2 aborts; Start held with RST is only taken after RST drops.
        for (int k = 0; k < 2; k++) begin
            issue(k, 16'h0205, 16'h0003, 1'b0);
            drain(k);
            start[k]  = 1'b1;
            a_in[k]   = 16'h4321;
            b_in[k]   = 16'h0123;
            bin_in[k] = 1'b0;
            @(posedge CLK);
            #1;
            start[k] = 1'b0;
            repeat (2) @(posedge CLK);
            #1;
            RST       = 1'b1;
            start[k]  = 1'b1;
            a_in[k]   = 16'h0300;
            b_in[k]   = 16'h0100;
            bin_in[k] = 1'b1;
            @(posedge CLK);
            #1;
            RST = 1'b0;
            check_reset_state(k);
            @(posedge CLK);
            #1;
            exp_q[k].push_back(model(16'h0300, 16'h0100, 1'b1, cyc + lat(k)));
            start[k] = 1'b0;
            check("busy_after_rst_start", k, int'(busy[k]), 1);
            drain(k);
        end

        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 12; i++) begin
                ra = 16'($urandom);
                rb = 16'($urandom);
                rc = 16'($urandom);
                rd = 16'($urandom);
                if (i % 3 == 0) rb = ra;
                if ($urandom_range(1, 0) == 1)
                    issue_hold(k, ra, rb, 1'($urandom), rc, rd, 1'($urandom));
                else
                    issue(k, ra, rb, 1'($urandom));
                drain(k);
                repeat ($urandom_range(2, 0)) @(posedge CLK);
                #1;
            end
        end

        repeat (3) @(posedge CLK);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
